// File: rtl/onoff_mon_pkg.sv
// onoff_mon_pkg: shared state type, default record layout and saturating increment for the ON-run monitor.
package onoff_mon_pkg;
  localparam int REC_W = 8;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} state_t;
  typedef struct packed {
    logic             timeout;
    logic [REC_W-1:0] len;
  } rec_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/onoff_rec_slot.sv
// onoff_rec_slot: single-entry valid/ready holding register; a load into a stalled full slot is dropped and flagged.
module onoff_rec_slot #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_rec,
  input  logic         i_ready,
  input  logic         i_clr_ovf,
  output logic         o_valid,
  output logic [W-1:0] o_rec,
  output logic         o_overflow
);
  logic         r_valid;
  logic [W-1:0] r_rec;
  logic         r_ovf;
  logic         w_drop;
  assign w_drop = i_load && r_valid && !i_ready;
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_valid <= 1'b0;
      r_rec   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= i_load || (r_valid && !i_ready);
      if (i_load && !w_drop) r_rec <= i_rec;
      // a drop in the same cycle as a clear keeps the flag set
      r_ovf   <= w_drop || (r_ovf && !i_clr_ovf);
    end
  end
  assign o_valid    = r_valid;
  assign o_rec      = r_rec;
  assign o_overflow = r_ovf;
endmodule

// File: rtl/onoff_run_monitor.sv
// onoff_run_monitor: measures each ON interval of level_in, emits a length record and raises a live timeout alarm.
module onoff_run_monitor
  import onoff_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             level_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_len,
  output logic             rec_timeout,
  output logic             alarm,
  output logic             overflow,
  input  logic             clr_ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_emit;
  logic [CNT_W:0]   w_rec;
  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
  always_comb begin
    w_state_nxt = level_in ? ON : OFF;
    w_cnt_nxt   = !level_in ? '0 : (r_state == ON) ? w_cnt_inc : CNT_W'(1);
    w_emit      = (r_state == ON) && !level_in;
  end
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  assign alarm = (r_state == ON) && (r_cnt >= TO);
  onoff_rec_slot #(.W(CNT_W + 1)) u_slot (
    .clk       (clk),
    .areset_n  (areset_n),
    .i_load    (w_emit),
    .i_rec     ({r_cnt >= TO, r_cnt}),
    .i_ready   (rec_ready),
    .i_clr_ovf (clr_ovf),
    .o_valid   (rec_valid),
    .o_rec     (w_rec),
    .o_overflow(overflow)
  );
  assign rec_len     = w_rec[CNT_W-1:0];
  assign rec_timeout = w_rec[CNT_W];
endmodule
